// File: rtl/draw_pkg.sv
// Shared definitions for the segment word renderer: stroke directions,
// table-entry field widths, FSM states and default screen bounds.
package draw_pkg;

    typedef enum logic [1:0] {
        DIR_H  = 2'd0,
        DIR_V  = 2'd1,
        DIR_DD = 2'd2,
        DIR_DU = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

    // Offsets are relative to the word origin inside a 20x5 glyph box.
    localparam int DX_W = 5;
    localparam int DY_W = 3;

    localparam int H_RES_DEF = 160;
    localparam int V_RES_DEF = 120;

    typedef struct packed {
        logic [DX_W-1:0] dx;
        logic [DY_W-1:0] dy;
        dir_t            dir;
    } seg_geom_t;

    function automatic seg_geom_t mk_geom(input int dx, input int dy, input dir_t dir);
        seg_geom_t g;
        g.dx  = DX_W'(dx);
        g.dy  = DY_W'(dy);
        g.dir = dir;
        return g;
    endfunction

endpackage

// File: rtl/seg_table_rom.sv
// Stroke table for one word: registered read of {dx0, dy0, dir, len} by index.
module seg_table_rom
    import draw_pkg::*;
#(
    parameter int          NUM_SEG = 11,
    parameter int          LEN_W   = 4,
    parameter int          IDX_W   = 4,
    parameter logic [31:0] WORD    = "LIVE"
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    output seg_geom_t        geom,
    output logic [LEN_W-1:0] len
);

    seg_geom_t        geom_rd;
    logic [LEN_W-1:0] len_rd;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        geom_rd = mk_geom(0, 0, DIR_H);
        len_rd  = '0;
        if (WORD == "TEST") begin
            case (int'(idx))
                0: begin geom_rd = mk_geom(0, 0, DIR_H);  len_rd = LEN_W'(3); end
                1: begin geom_rd = mk_geom(2, 0, DIR_V);  len_rd = '0;        end
                2: begin geom_rd = mk_geom(0, 4, DIR_DU); len_rd = LEN_W'(2); end
                default: ;
            endcase
        end else begin
            len_rd = LEN_W'(5);
            case (int'(idx))
                0:  geom_rd = mk_geom(0,  0, DIR_V);   // L
                1:  geom_rd = mk_geom(0,  4, DIR_H);
                2:  geom_rd = mk_geom(4,  0, DIR_H);   // I
                3:  geom_rd = mk_geom(6,  0, DIR_V);
                4:  geom_rd = mk_geom(4,  4, DIR_H);
                5:  geom_rd = mk_geom(8,  0, DIR_DD);  // V
                6:  geom_rd = mk_geom(12, 4, DIR_DU);
                7:  geom_rd = mk_geom(15, 0, DIR_V);   // E
                8:  geom_rd = mk_geom(15, 0, DIR_H);
                9:  geom_rd = mk_geom(15, 2, DIR_H);
                10: geom_rd = mk_geom(15, 4, DIR_H);
                default: len_rd = '0;
            endcase
        end
        if (int'(idx) >= NUM_SEG) len_rd = '0;
    end

    // NOTE: the read register carries constant table data, so it needs no reset.
    always_ff @(posedge clk) begin
        geom <= geom_rd;
        len  <= len_rd;
    end

endmodule

// File: rtl/segment_word_draw.sv
// Walks the stroke table of a word and emits one clipped pixel per accepted
// handshake; origin and colour are captured when a draw starts.
module segment_word_draw
    import draw_pkg::*;
#(
    parameter int          NUM_SEG = 11,
    parameter int          LEN_W   = 4,
    parameter int          X_W     = 8,
    parameter int          Y_W     = 7,
    parameter int          H_RES   = H_RES_DEF,
    parameter int          V_RES   = V_RES_DEF,
    parameter logic [31:0] WORD    = "LIVE"
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] x_org,
    input  logic [Y_W-1:0] y_org,
    input  logic [2:0]     colour_in,
    input  logic           plot_ready,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    localparam int               IDX_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

    state_t           state;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] index_nxt;
    logic [LEN_W-1:0] step;
    logic [LEN_W-1:0] step_sel;
    logic [X_W-1:0]   org_x;
    logic [Y_W-1:0]   org_y;
    seg_geom_t        geom;
    logic [LEN_W-1:0] len;
    logic [X_W-1:0]   px;
    logic [Y_W-1:0]   py;
    logic             pin;
    logic             advance;
    logic             last_step;
    logic             last_seg;

    // The table is addressed with the next index so the entry is ready during LOAD.
    seg_table_rom #(
        .NUM_SEG (NUM_SEG),
        .LEN_W   (LEN_W),
        .IDX_W   (IDX_W),
        .WORD    (WORD)
    ) u_rom (
        .clk  (clk),
        .idx  (index_nxt),
        .geom (geom),
        .len  (len)
    );

    assign last_seg  = (index == LAST_IDX);
    assign last_step = (({1'b0, step} + (LEN_W+1)'(1)) == {1'b0, len});
    assign advance   = !plot || plot_ready;

    // Pixel to present next: step 0 when leaving LOAD, step+1 while drawing.
    always_comb begin
        step_sel = (state == DRAW) ? step + LEN_W'(1) : '0;
        px       = org_x + X_W'(geom.dx);
        py       = org_y + Y_W'(geom.dy);
        case (geom.dir)
            DIR_H:  px = px + X_W'(step_sel);
            DIR_V:  py = py + Y_W'(step_sel);
            DIR_DD: begin px = px + X_W'(step_sel); py = py + Y_W'(step_sel); end
            DIR_DU: begin px = px + X_W'(step_sel); py = py - Y_W'(step_sel); end
        endcase
        pin = (int'(px) < H_RES) && (int'(py) < V_RES);
    end

    always_comb begin
        index_nxt = index;
        if (reset) begin
            index_nxt = '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) index_nxt = '0;
                LOAD:       if (len == '0 && !last_seg) index_nxt = index + IDX_W'(1);
                DRAW:       if (advance && last_step && !last_seg) index_nxt = index + IDX_W'(1);
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        index <= index_nxt;
        if (reset) begin
            state  <= IDLE;
            step   <= '0;
            org_x  <= '0;
            org_y  <= '0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        org_x  <= x_org;
                        org_y  <= y_org;
                        colour <= colour_in;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    step <= '0;
                    if (len == '0) begin
                        if (last_seg) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= DRAW;
                        x     <= px;
                        y     <= py;
                        plot  <= pin;
                    end
                end
                DRAW: begin
                    // Clipped pixels advance on their own; visible ones wait for plot_ready.
                    if (advance) begin
                        if (last_step) begin
                            plot <= 1'b0;
                            if (last_seg) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= LOAD;
                            end
                        end else begin
                            step <= step + LEN_W'(1);
                            x    <= px;
                            y    <= py;
                            plot <= pin;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/segment_word_draw.md
SEGMENT_WORD_DRAW -- requirements
Module: segment_word_draw

Interface
REQ-001 Parameter NUM_SEG, default 11, number of stroke segments in the word table.
REQ-002 Parameter LEN_W, default 4, width of per-segment length field (max length 2^LEN_W-1).
REQ-003 Parameter X_W, default 8; Y_W, default 7; pixel coordinate widths.
REQ-004 Parameter H_RES, default 160; V_RES, default 120; visible screen bounds.
REQ-005 Parameter WORD, default "LIVE", selects segment table contents.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  request to draw the word; sampled only in IDLE or DONE.
REQ-009 x_org  input  X_W  word origin x; y_org  input  Y_W  word origin y.
REQ-010 colour_in  input  3  draw colour, latched at start.
REQ-011 plot_ready  input  1  downstream (VGA adapter/arbiter) accepts current pixel.
REQ-012 x  output  X_W, y  output  Y_W, colour  output  3  current pixel.
REQ-013 plot  output  1  pixel valid; busy  output  1  draw in progress; done  output  1  word complete.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, DRAW, DONE.
REQ-015 IDLE: start=1 latches x_org, y_org, colour_in, clears segment index, goes to LOAD next cycle.
REQ-016 LOAD: reads table entry {dx0, dy0, dir, len} for current index (one-cycle read), sets step=0, goes to DRAW.
REQ-017 dir encoding: H (x+step), V (y+step), DD (x+step, y+step), DU (x+step, y-step).
REQ-018 DRAW: pixel = (org_x+dx0+step_x, org_y+dy0+step_y), truncated modulo 2^X_W / 2^Y_W.
REQ-019 DRAW: plot=1 when pixel is inside x<H_RES and y<V_RES; otherwise plot=0 and step advances without waiting on plot_ready.
REQ-020 x, y, colour, plot SHALL hold stable while plot=1 and plot_ready=0.
REQ-021 Step advances only on plot=1 and plot_ready=1, or on a clipped pixel.
REQ-022 Each segment SHALL emit exactly len pixels (step 0..len-1); no repeated final pixel.
REQ-023 Entry with len=0 emits nothing; FSM goes from LOAD directly to the next LOAD, or to DONE if last.
REQ-024 After last step of segment index<NUM_SEG-1: index++, go to LOAD; of index NUM_SEG-1: go to DONE.
REQ-025 busy=1 in LOAD and DRAW; plot=0 outside DRAW.
REQ-026 DONE: done=1 held until start=1, which restarts exactly as from IDLE (new origin/colour latched).
REQ-027 start during LOAD/DRAW SHALL be ignored; the in-progress word completes unchanged.
REQ-028 Latency, no stall, no clip: start at cycle 0, first plot at cycle 2, done rises 1 cycle after final accepted pixel; total busy cycles = NUM_SEG + sum(len).

Reset
REQ-029 reset=1 SHALL force IDLE, index=0, step=0, x=0, y=0, colour=0, plot=0, busy=0, done=0 on the next edge.
REQ-030 reset asserted mid-draw SHALL abort immediately; no further plot until a new start after reset deasserts.

Structure
REQ-031 Shared package draw_pkg SHALL hold dir encodings, table-entry field widths, and default H_RES/V_RES.
REQ-032 One sub-module seg_table_rom (registered read, WORD-selected case table, index in, entry out) SHALL hold segment data.
REQ-033 Default "LIVE" table: 11 segments, len 5 each, offsets spanning L, I, V, E glyphs within a 20x5 box.

Verification
REQ-034 Origin (10,10), plot_ready=1, start pulse -> 55 plots, first pixel (10,10), done at cycle 67, busy high 66 cycles.
REQ-035 plot_ready toggled 1/0 every cycle -> same 55-pixel sequence in the same order, x/y stable during stall, done delayed by 55 cycles.
REQ-036 Origin (150,10) -> pixels with x>=160 never plotted, plotted pixel count <55, done still asserted.
REQ-037 start re-pulsed at cycle 20 of draw -> ignored, output identical to REQ-034; start in DONE with origin (40,60) -> full redraw offset by (30,50).
REQ-038 reset asserted at cycle 30 of draw -> next cycle plot=0, busy=0, done=0, x=y=0; no plot until the next start.
REQ-039 Custom table with one len=0 entry -> that segment skipped, total plots reduced by 0, index still reaches NUM_SEG-1 and done asserts.
